// File: rtl/fifo_uart_drain_sched.sv
// fifo_uart_drain_sched: periodic scan of the FIFO read port that drains every queued byte into the UART TX.
// Optional macro DRAIN_STATS_EN adds o_burst_len/o_last_len burst byte counters.
module fifo_uart_drain_sched #(
    parameter int DSIZE  = 8,
    parameter int PERIOD = 5000000,
    parameter int CW     = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_fifo_empty,
    input  logic [DSIZE-1:0] i_fifo_rdata,
    output logic             o_fifo_rinc,
    output logic [DSIZE-1:0] o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_busy,
    output logic             o_burst_active,
    output logic             o_scan_tick
`ifdef DRAIN_STATS_EN
    ,
    output logic [15:0]      o_burst_len,
    output logic [15:0]      o_last_len
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_POP, S_RDWAIT, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_CHECK} state_t;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_scan_tick;
    logic             r_fifo_rinc;
    logic             r_tx_start;
    logic             r_burst_active;
    logic [DSIZE-1:0] r_tx_data;
    logic             w_wrap;
    logic             w_go;
    logic             w_more;
    assign w_wrap = r_cnt == LAST;
    assign w_go   = r_scan_tick && i_enable && !i_fifo_empty;
    assign w_more = !i_fifo_empty && i_enable;
    assign o_fifo_rinc    = r_fifo_rinc;
    assign o_tx_start     = r_tx_start;
    assign o_tx_data      = r_tx_data;
    assign o_burst_active = r_burst_active;
    assign o_scan_tick    = r_scan_tick;
    // interval counter: free-running while enabled, tick registered on the wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_cnt       <= (i_enable && !w_wrap) ? r_cnt + 1'b1 : '0;
            r_scan_tick <= i_enable && w_wrap;
        end
    end
    // drain FSM; tx_start is decided one cycle early so it is high during START itself
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_fifo_rinc    <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
            r_burst_active <= 1'b0;
        end else begin
            r_fifo_rinc <= 1'b0;
            r_tx_start  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state        <= w_go ? S_POP : S_IDLE;
                    r_fifo_rinc    <= w_go;
                    r_burst_active <= w_go;
                end
                S_POP:     r_state <= S_RDWAIT;
                S_RDWAIT:  r_state <= S_LOAD;
                S_LOAD: begin
                    r_tx_data  <= i_fifo_rdata;
                    r_tx_start <= !i_tx_busy;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_tx_start <= !r_tx_start && !i_tx_busy;
                    r_state    <= r_tx_start ? S_WAIT_HI : S_START;
                end
                S_WAIT_HI: r_state <= i_tx_busy ? S_WAIT_LO : S_WAIT_HI;
                S_WAIT_LO: r_state <= i_tx_busy ? S_WAIT_LO : S_CHECK;
                S_CHECK: begin
                    r_state        <= w_more ? S_POP : S_IDLE;
                    r_fifo_rinc    <= w_more;
                    r_burst_active <= w_more;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end
`ifdef DRAIN_STATS_EN
    logic [15:0] r_burst_len;
    logic [15:0] r_last_len;
    assign o_burst_len = r_burst_len;
    assign o_last_len  = r_last_len;
    // per-burst start counter (saturating) and snapshot of the finished burst length
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_burst_len <= '0;
            r_last_len  <= '0;
        end else begin
            r_burst_len <= (r_state == S_IDLE && w_go) ? 16'h0 :
                           (r_tx_start && r_burst_len != 16'hFFFF) ? r_burst_len + 16'h1 : r_burst_len;
            r_last_len  <= (r_state == S_CHECK && !w_more) ? r_burst_len : r_last_len;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_uart_drain_sched.sv
// tb_fifo_uart_drain_sched: FIFO/UART models, vector table and scoreboard for the drain scheduler.
module tb_fifo_uart_drain_sched;
    localparam int PERIOD = 10;
    bit          clk;
    logic        rst;
    logic        enable;
    bit          fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_rinc;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        burst_active;
    logic        scan_tick;
`ifdef DRAIN_STATS_EN
    logic [15:0] burst_len;
    logic [15:0] last_len;
`endif
    fifo_uart_drain_sched #(.DSIZE(8), .PERIOD(PERIOD), .CW(24)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_fifo_empty(fifo_empty),
        .i_fifo_rdata(fifo_rdata), .o_fifo_rinc(fifo_rinc), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .i_tx_busy(tx_busy), .o_burst_active(burst_active),
        .o_scan_tick(scan_tick)
`ifdef DRAIN_STATS_EN
        , .o_burst_len(burst_len), .o_last_len(last_len)
`endif
    );
    always #5 clk = ~clk;

    // FIFO model: registered read, data valid the cycle after rinc
    bit         wr_en;
    logic [7:0] wr_data;
    logic [7:0] fq[$];
    always @(posedge clk) begin
        if (fifo_rinc && fq.size() != 0) fifo_rdata <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // UART model: busy for busy_len cycles after each start, or held by force_busy
    int busy_len;
    bit force_busy;
    int bcnt;
    always @(posedge clk) bcnt <= (tx_start === 1'b1) ? busy_len : (bcnt > 0 ? bcnt - 1 : 0);
    assign tx_busy = (bcnt != 0) || force_busy;

    // monitor
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;
    int n_starts, n_rinc, n_ticks, n_bursts, n_bad_pop, n_bad_rst, n_dbl;
    int last_tick_cyc, last_rinc_cyc, start_lat, pop_lat, busy_fall_cyc, burst_fall_cyc;
    bit prev_burst, prev_busy, prev_start;
    logic [7:0] got [0:63];
    always @(negedge clk) begin
        if (scan_tick === 1'b1) begin
            n_ticks <= n_ticks + 1;
            last_tick_cyc <= cyc;
        end
        if (fifo_rinc === 1'b1) begin
            n_rinc <= n_rinc + 1;
            last_rinc_cyc <= cyc;
            if (fifo_empty) n_bad_pop <= n_bad_pop + 1;
        end
        if (tx_start === 1'b1) begin
            got[n_starts[5:0]] <= tx_data;
            n_starts <= n_starts + 1;
            start_lat <= cyc - last_rinc_cyc;
            if (prev_start) n_dbl <= n_dbl + 1;
        end
        if (rst === 1'b1 && (fifo_rinc === 1'b1 || tx_start === 1'b1)) n_bad_rst <= n_bad_rst + 1;
        if (burst_active === 1'b1 && !prev_burst) begin
            n_bursts <= n_bursts + 1;
            pop_lat <= cyc - last_tick_cyc;
        end
        if (burst_active === 1'b0 && prev_burst) burst_fall_cyc <= cyc;
        if (tx_busy === 1'b0 && prev_busy) busy_fall_cyc <= cyc;
        prev_burst <= (burst_active === 1'b1);
        prev_busy  <= (tx_busy === 1'b1);
        prev_start <= (tx_start === 1'b1);
    end

    int errors, checks, rd_idx;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_bytes(input string nm);
        while (rd_idx < n_starts) begin
            if (exp_q.size() == 0) begin
                chk({nm, " unexpected bytes"}, n_starts - rd_idx, 0);
                rd_idx = n_starts;
            end else begin
                chk({nm, " byte"}, int'(got[rd_idx[5:0]]), int'(exp_q.pop_front()));
                rd_idx++;
            end
        end
    endtask

    task automatic wait_done(input int target, input string nm);
        int k;
        for (k = 0; k < 800 && !(n_starts >= target && burst_active === 1'b0 && fifo_empty); k++) step();
        chk({nm, " completed in budget"}, int'(k < 800), 1);
    endtask

    typedef struct {
        int          n;
        logic [23:0] bytes;
        int          busy;
        int          exp_starts;
    } vec_t;
    vec_t tbl [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, r0, b0, t0, c0, f0, k;
        tbl[0] = '{3, 24'h434241, 20, 3};
        tbl[1] = '{1, 24'h0000A5, 5, 1};
        tbl[2] = '{2, 24'h00FF00, 1, 2};
        tbl[3] = '{3, 24'h302010, 3, 3};
        rst = 1'b1;
        enable = 1'b0;
        busy_len = 20;
        step(); step(); step();
        chk("reset fifo_rinc", int'(fifo_rinc), 0);
        chk("reset tx_start", int'(tx_start), 0);
        chk("reset tx_data", int'(tx_data), 0);
        chk("reset burst_active", int'(burst_active), 0);
        chk("reset scan_tick", int'(scan_tick), 0);
        rst = 1'b0;
        t0 = n_ticks;
        repeat (30) step();
        chk("disabled ticks", n_ticks - t0, 0);
        // empty FIFO scanning
        enable = 1'b1;
        t0 = n_ticks;
        repeat (50) step();
        chk("empty ticks in 50 cycles", n_ticks - t0, 5);
        chk("empty pops", n_rinc, 0);
        chk("empty starts", n_starts, 0);
        // table-driven bursts
        for (int i = 0; i < 4; i++) begin
            busy_len = tbl[i].busy;
            s0 = n_starts; r0 = n_rinc; b0 = n_bursts;
            for (int j = 0; j < tbl[i].n; j++) push(tbl[i].bytes[8*j +: 8]);
            wait_done(s0 + tbl[i].exp_starts, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d starts", i), n_starts - s0, tbl[i].exp_starts);
            chk($sformatf("vec%0d pops", i), n_rinc - r0, tbl[i].exp_starts);
            chk($sformatf("vec%0d bursts", i), n_bursts - b0, 1);
            check_bytes($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tx_data held", i), int'(tx_data), int'(tbl[i].bytes[8*(tbl[i].n-1) +: 8]));
            chk($sformatf("vec%0d rinc->start latency", i), start_lat, 3);
            chk($sformatf("vec%0d tick->pop latency", i), pop_lat, 1);
            chk($sformatf("vec%0d busy fall->burst fall", i), burst_fall_cyc - busy_fall_cyc, 2);
            repeat (5) step();
        end
        // write landing mid-burst joins the same burst
        busy_len = 20;
        s0 = n_starts; b0 = n_bursts;
        push(8'h41);
        for (k = 0; k < 100 && n_starts == s0; k++) step();
        chk("midwrite first start seen", int'(n_starts > s0), 1);
        push(8'h55);
        wait_done(s0 + 2, "midwrite");
        chk("midwrite starts", n_starts - s0, 2);
        chk("midwrite bursts", n_bursts - b0, 1);
        check_bytes("midwrite");
`ifdef DRAIN_STATS_EN
        chk("midwrite last_len", int'(last_len), 2);
`endif
        // long burst drops ticks; the next burst waits for a fresh tick
        s0 = n_starts; b0 = n_bursts; t0 = n_ticks;
        for (int j = 0; j < 3; j++) push(8'hC0 + 8'(j));
        wait_done(s0 + 3, "long");
        chk("long bursts", n_bursts - b0, 1);
        chk("long spans >=3 ticks", int'(n_ticks - t0 >= 3), 1);
        check_bytes("long");
        f0 = burst_fall_cyc;
        push(8'h77);
        wait_done(s0 + 4, "after long");
        chk("after long bursts", n_bursts - b0, 2);
        chk("after long tick->pop", pop_lat, 1);
        chk("after long tick after idle", int'(last_tick_cyc > f0), 1);
        check_bytes("after long");
        // UART already busy at START
        busy_len = 4;
        force_busy = 1'b1;
        s0 = n_starts; r0 = n_rinc;
        push(8'h99);
        for (k = 0; k < 100 && n_rinc == r0; k++) step();
        chk("held busy pop seen", int'(n_rinc > r0), 1);
        repeat (30) step();
        chk("held busy no start", n_starts - s0, 0);
        force_busy = 1'b0;
        step(); step();
        chk("held busy single start", n_starts - s0, 1);
        wait_done(s0 + 1, "held busy");
        chk("held busy total starts", n_starts - s0, 1);
        check_bytes("held busy");
        // reset in WAIT_LO of the second byte
        busy_len = 20;
        s0 = n_starts;
        push(8'hD1); push(8'hD2); push(8'hD3);
        for (k = 0; k < 200 && n_starts < s0 + 2; k++) step();
        chk("rst second start seen", int'(n_starts >= s0 + 2), 1);
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("async rst fifo_rinc", int'(fifo_rinc), 0);
        chk("async rst tx_start", int'(tx_start), 0);
        chk("async rst tx_data", int'(tx_data), 0);
        chk("async rst burst_active", int'(burst_active), 0);
        chk("async rst scan_tick", int'(scan_tick), 0);
        repeat (5) step();
        b0 = n_bursts;
        c0 = cyc;
        rst = 1'b0;
        for (k = 0; k < 100 && n_bursts == b0; k++) step();
        chk("post-rst burst seen", int'(n_bursts > b0), 1);
        chk("post-rst tick after PERIOD", last_tick_cyc - c0, PERIOD);
        chk("post-rst tick->pop", pop_lat, 1);
        wait_done(s0 + 3, "post-rst");
        check_bytes("post-rst");
        // global invariants
        chk("pop while empty", n_bad_pop, 0);
        chk("back-to-back starts", n_dbl, 0);
        chk("activity during rst", n_bad_rst, 0);
        chk("one start per pop", n_starts, n_rinc);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_uart_drain_sched.md
Name: fifo_uart_drain_sched

Overview:
- Periodic scheduler between the async FIFO read port and the UART transmitter.
- Every PERIOD clocks it checks the FIFO; if data is present it drains the whole FIFO, one byte at a time, into the UART TX.
- Handles the FIFO pop/read latency and the UART start/busy handshake.
- Sits in the read-clock domain of the FIFO, alongside the UART TX core.

Parameters:
- DSIZE, 8: FIFO/UART data width in bits.
- PERIOD, 5000000: scan interval in clk cycles (100 ms at 50 MHz); must be >= 2.
- CW, 24: width of the interval counter; must satisfy 2^CW > PERIOD.

Ports:
- clk  in  1  system clock (FIFO read clock).
- rst  in  1  reset.
- enable  in  1  scheduler enable; low inhibits new scans and bursts.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DSIZE  FIFO read data; valid 1 cycle after fifo_rinc.
- fifo_rinc  out  1  FIFO read-increment pulse.
- tx_data  out  DSIZE  byte presented to the UART TX.
- tx_start  out  1  one-cycle start pulse to the UART TX.
- tx_busy  in  1  UART TX busy (high while shifting).
- burst_active  out  1  high from the first pop of a burst to the end of the last byte.
- scan_tick  out  1  one-cycle pulse at each interval boundary.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: fifo_rinc=0, tx_start=0, tx_data=0, burst_active=0, scan_tick=0, cnt=0, state=IDLE.
- Interval counter:
  - While enable=1, cnt increments each clk.
  - At cnt==PERIOD-1, cnt wraps to 0 and scan_tick pulses for 1 cycle (registered, same cycle as the wrap).
  - While enable=0, cnt is held at 0 and no tick is generated.
  - The counter runs freely during bursts.
- FSM states: IDLE, POP, RDWAIT, LOAD, START, WAIT_HI, WAIT_LO, CHECK.
  - IDLE: on scan_tick with enable=1 and fifo_empty=0, go to POP and set burst_active=1. Otherwise stay in IDLE.
  - POP: fifo_rinc=1 for exactly this cycle -> RDWAIT.
  - RDWAIT: one wait cycle for the registered FIFO read -> LOAD.
  - LOAD: tx_data <= fifo_rdata -> START.
  - START: if tx_busy=0, tx_start=1 for 1 cycle -> WAIT_HI. If tx_busy=1, hold in START with tx_start=0.
  - WAIT_HI: wait for tx_busy=1 -> WAIT_LO.
  - WAIT_LO: wait for tx_busy=0 -> CHECK.
  - CHECK:
    - If fifo_empty=0 and enable=1 -> POP (next byte, same burst).
    - Otherwise -> IDLE with burst_active=0.
- tx_data holds its value between bytes; it changes only in LOAD.
- Latency: scan_tick to fifo_rinc = 1 cycle; fifo_rinc to tx_start = 3 cycles when the UART is idle.
- Boundary conditions:
  - Ticks arriving in any state other than IDLE are dropped, not queued. The next scan is the following tick.
  - FIFO writes that land during a burst are drained in the same burst, because fifo_empty is sampled in CHECK.
  - FIFO becomes empty in the same cycle as CHECK: the burst ends and no extra pop is issued.
  - fifo_rinc is never asserted while fifo_empty=1.
  - enable falling mid-burst: the current byte completes; CHECK then goes to IDLE.
  - Reset mid-burst: immediate abort to reset values. No tx_start or fifo_rinc is issued after rst asserts.
  - tx_busy already high at START: wait; no lost byte and no double start.
  - Exactly one tx_start is issued per fifo_rinc.

Optional Feature:
- Macro: DRAIN_STATS_EN.
- Defined: adds output ports burst_len [15:0] and last_len [15:0].
  - burst_len clears at burst start and increments on each tx_start, saturating at 16'hFFFF.
  - last_len is loaded with the final burst_len when CHECK exits to IDLE.
  - Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- PERIOD=10, enable=1, FIFO empty for 50 cycles -> scan_tick every 10 cycles; fifo_rinc and tx_start never asserted.
- FIFO preloaded with 0x41, 0x42, 0x43; UART model busy for 20 cycles after each start -> exactly 3 tx_start pulses carrying tx_data 0x41, 0x42, 0x43 in order; burst_active falls after the third busy fall; the FIFO ends empty.
- Mid-burst write of 0x55 while 0x41 is being sent -> 0x55 is sent in the same burst, with 2 total starts; with DRAIN_STATS_EN, last_len=2.
- Long burst spanning 3 tick times -> no extra burst starts; the ticks during the burst are dropped; the next burst begins only on the first tick after the return to IDLE.
- tx_busy held high for 30 cycles when START is reached -> tx_start is delayed until busy falls and then pulses once.
- rst asserted in WAIT_LO of the 2nd byte -> outputs at reset values asynchronously. After release with the FIFO non-empty, the first pop occurs 1 cycle after the next scan_tick (PERIOD cycles later).
